// File: rtl/mem_ctrl_sequencer.sv
// mem_ctrl_sequencer: expands SET_ADDR/WRITE/PLAY/STOP_ALL commands into per-channel control-byte sequences.
// Define MEM_SEQ_ABORT_EN to add an abort input that cancels a running command.
module mem_ctrl_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_ch,
    input  logic [ADDR_W-1:0] cmd_arg,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic              err,
    output logic [7:0]        ctrl_0,
    output logic [7:0]        ctrl_1,
    output logic [7:0]        ctrl_2,
    output logic [7:0]        ctrl_3
);
    localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW = $clog2(SW + 1);
    localparam logic [1:0] OP_SET = 2'b00, OP_WR = 2'b01, OP_PLAY = 2'b10;

    typedef enum logic [2:0] {IDLE, SHIFT, STROBE, ADV, WAIT_DATA} state_t;

    state_t            state_q;
    logic [1:0]        op_q, ch_q;
    logic [SW-1:0]     sh_q;
    logic [CW-1:0]     cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [3:0]        play_q, dout_q, mode_q;
    logic              din_q, wen_q, wr_q, sa_q, na_q, done_q, err_q;
    logic              ab;
    logic [3:0]        hit;
    logic [7:0]        ctrl [4];

`ifdef MEM_SEQ_ABORT_EN
    assign ab = abort;
`else
    assign ab = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            ch_q    <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            play_q  <= '0;
            dout_q  <= '0;
            mode_q  <= '0;
            din_q   <= 1'b0;
            wen_q   <= 1'b0;
            wr_q    <= 1'b0;
            sa_q    <= 1'b0;
            na_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            sa_q   <= 1'b0;
            na_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != IDLE && ab) begin
                state_q <= IDLE;
                din_q   <= 1'b0;
                wen_q   <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (cmd_valid) begin
                        ch_q <= cmd_ch;
                        op_q <= cmd_op;
                        // Address and data loads are refused while the channel is playing.
                        if (!cmd_op[1] && play_q[cmd_ch]) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (cmd_op == OP_SET) begin
                            state_q <= SHIFT;
                            din_q   <= cmd_arg[ADDR_W-1];
                            sh_q    <= SW'(cmd_arg) << (SW - ADDR_W + 1);
                            cnt_q   <= CW'(ADDR_W - 1);
                        end else if (cmd_op == OP_WR) begin
                            if (cmd_len == '0) done_q <= 1'b1;
                            else begin
                                state_q <= WAIT_DATA;
                                len_q   <= cmd_len;
                            end
                        end else if (cmd_op == OP_PLAY) begin
                            play_q[cmd_ch] <= cmd_arg[0];
                            dout_q[cmd_ch] <= cmd_arg[0];
                            mode_q[cmd_ch] <= cmd_arg[1];
                            done_q         <= 1'b1;
                        end else begin
                            play_q <= '0;
                            dout_q <= '0;
                            done_q <= 1'b1;
                        end
                    end
                    WAIT_DATA: if (wdata_valid) begin
                        state_q <= SHIFT;
                        wen_q   <= 1'b1;
                        din_q   <= wdata[DATA_W-1];
                        sh_q    <= SW'(wdata) << (SW - DATA_W + 1);
                        cnt_q   <= CW'(DATA_W - 1);
                    end
                    SHIFT: if (cnt_q != '0) begin
                        din_q <= sh_q[SW-1];
                        sh_q  <= sh_q << 1;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= STROBE;
                        din_q   <= 1'b0;
                        sa_q    <= op_q == OP_SET;
                        wr_q    <= op_q == OP_WR;
                    end
                    STROBE: begin
                        wen_q <= 1'b0;
                        if (op_q == OP_SET) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ADV;
                            na_q    <= 1'b1;
                        end
                    end
                    ADV: if (len_q == LEN_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= WAIT_DATA;
                        len_q   <= len_q - LEN_W'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_ready   = state_q == IDLE;
    assign wdata_ready = state_q == WAIT_DATA;
    assign done        = done_q;
    assign err         = err_q;
    assign hit         = 4'b0001 << ch_q;

    for (genvar i = 0; i < 4; i++) begin : g_ctrl
        assign ctrl[i] = {dout_q[i], hit[i] & din_q, mode_q[i], hit[i] & wen_q,
                          play_q[i], hit[i] & na_q, hit[i] & sa_q, hit[i] & wr_q};
    end

    assign ctrl_0 = ctrl[0];
    assign ctrl_1 = ctrl[1];
    assign ctrl_2 = ctrl[2];
    assign ctrl_3 = ctrl[3];
endmodule
